lb_arb: RTL
===========

LB_ARB -- requirements
Module: lb_arb

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 16'd255, meaning the number of WAIT cycles allowed for lb_rd_rdy before a read is aborted (range 1..65535).
REQ-002 The block SHALL have these ports, one per line, as name, direction, width, meaning:
- clk_lb  in  1  the single clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 request, level, held until m0_ack.
- m0_rnw  in  1  master 0 command: 1 = read, 0 = write; valid while m0_req=1.
- m0_addr  in  32  master 0 address.
- m0_wr_d  in  32  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m0_err  out  1  read timeout flag, valid with m0_ack.
- m0_rd_d  out  32  read data to master 0, valid with m0_ack.
- m1_req, m1_rnw, m1_addr, m1_wr_d, m1_ack, m1_err, m1_rd_d  as m0_*, for master 1.
- lb_wr  out  1  local-bus write strobe.
- lb_rd  out  1  local-bus read strobe.
- lb_addr  out  32  local-bus address.
- lb_wr_d  out  32  local-bus write data.
- lb_rd_d  in  32  local-bus read data.
- lb_rd_rdy  in  1  local-bus read data valid.
- grant  out  2  one-hot owner of the bus; 00 when IDLE.

Function
REQ-003 The state machine SHALL have the states IDLE, ISSUE, WAIT and ACK, with the following transitions:
- IDLE -> ISSUE when any mN_req=1.
- ISSUE -> ACK for a write.
- ISSUE -> WAIT for a read.
- WAIT -> ACK on lb_rd_rdy=1 or on timeout.
- ACK -> IDLE.
REQ-004 Arbitration SHALL be round-robin in IDLE:
- A sole requester wins.
- If both request, the master not granted last wins.
- last_grant resets to master 1, so master 0 wins the first contest.
REQ-005 On grant, the winner's rnw, addr and wr_d SHALL be registered, and lb_addr and lb_wr_d SHALL hold those values from ISSUE until return to IDLE.
REQ-006 lb_wr or lb_rd SHALL be high for exactly the one ISSUE cycle, and never both.
REQ-007 If a request is sampled in IDLE at cycle t, the strobe SHALL be at t+1, and a write SHALL assert mN_ack at t+2.
REQ-008 In WAIT, the first cycle with lb_rd_rdy=1 SHALL capture lb_rd_d into mN_rd_d and assert mN_ack (with mN_err=0) in the following cycle.
REQ-009 lb_rd_rdy asserted in IDLE, ISSUE or ACK, or during a write, SHALL be ignored.
REQ-010 mN_ack SHALL be a single-cycle pulse to the granted master only.
REQ-011 mN_rd_d SHALL hold its value until that master's next read completes.
REQ-012 After ACK the block SHALL spend at least one IDLE cycle, so a master dropping req on the edge after ack is never re-granted.
REQ-013 Changes of mN_req, mN_rnw, mN_addr or mN_wr_d after grant SHALL be ignored until IDLE.
REQ-014 grant SHALL be one-hot during ISSUE, WAIT and ACK, and 00 in IDLE.

Reset
REQ-015 While reset_n=0, the block SHALL force the following immediately and asynchronously:
- state = IDLE
- lb_wr = lb_rd = 0
- lb_addr = lb_wr_d = 0
- mN_ack = mN_err = 0
- mN_rd_d = 0
- grant = 00
- timeout counter = 0
- last_grant = master 1
REQ-016 Reset asserted mid-transaction SHALL abandon the transaction with no ack; after reset_n deasserts, operation SHALL resume from IDLE on the first clk_lb edge.

Configuration
REQ-017 With LB_ARB_TIMEOUT_EN defined, the timeout SHALL behave as follows:
- A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
- When the counter equals TIMEOUT_CYC with lb_rd_rdy=0, the state goes to ACK with mN_rd_d=32'hDEADBEEF and mN_err=1.
- lb_rd_rdy=1 in the same cycle the counter reaches TIMEOUT_CYC wins: the read completes normally with mN_err=0.
REQ-018 Without LB_ARB_TIMEOUT_EN, WAIT SHALL persist until lb_rd_rdy, the counter logic SHALL be absent, and mN_err SHALL be tied 0.

Verification
REQ-019 Reset then m0 write (addr 0x10, data 0x00000001) -> lb_wr is one cycle at t+1 with lb_addr=0x10 and lb_wr_d=0x1, m0_ack at t+2, m0_err=0.
REQ-020 m1 read of 0x00 with slave returning 0x11223344 one cycle after lb_rd -> m1_rd_d=0x11223344 and m1_ack one cycle after lb_rd_rdy, grant=10 throughout.
REQ-021 m0 and m1 raise req in the same cycle, three times in a row -> the grant order is m0, m1, m0, with exactly one lb strobe per transaction.
REQ-022 With LB_ARB_TIMEOUT_EN and TIMEOUT_CYC=4, a read that never gets lb_rd_rdy -> m0_ack with m0_rd_d=0xDEADBEEF and m0_err=1; a repeat run with rdy arriving exactly in the timeout cycle -> real data returned and err=0.
REQ-023 reset_n pulled low during WAIT -> all outputs go to reset values without a clock edge, no ack is issued, and a subsequent m1 write completes normally.
REQ-024 Stray lb_rd_rdy pulses in IDLE and during a write -> no mN_ack and no mN_rd_d change.

Source files
------------

// File: rtl/lb_arb.sv
// Two-master round-robin arbiter onto a single local bus (IDLE/ISSUE/WAIT/ACK).
// Optional read timeout enabled by defining LB_ARB_TIMEOUT_EN.
module lb_arb #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd255
) (
  input  logic        clk_lb,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_rnw,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_d,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rd_d,
  input  logic        m1_req,
  input  logic        m1_rnw,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_d,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rd_d,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_addr,
  output logic [31:0] lb_wr_d,
  input  logic [31:0] lb_rd_d,
  input  logic        lb_rd_rdy,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  grant_reg;
  logic        last_grant_reg;
  logic        rnw_reg;
  logic [31:0] addr_reg;
  logic [31:0] wd_reg;
  logic [31:0] rd_d_reg [2];
  logic        any_req;
  logic        win_idx;
  logic        tmo_hit;
  logic        err_q;
  logic [1:0]  ack_vec;
  logic [1:0]  err_vec;

  assign any_req = m0_req | m1_req;

  // On a contest the master that did not own the bus last time wins.
  always_comb begin
    win_idx = m1_req;
    if (m0_req && m1_req)
      win_idx = ~last_grant_reg;
  end

`ifdef LB_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg;
  logic        err_reg;

  assign tmo_hit = (tmo_cnt_reg == TIMEOUT_CYC);
  assign err_q   = err_reg;

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == S_ISSUE) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == S_WAIT) begin
      tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
    end
  end

  // Ready in the timeout cycle takes priority, so err only sets on a true timeout.
  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= 1'b0;
    end else if (state_reg == S_IDLE && any_req) begin
      err_reg <= 1'b0;
    end else if (state_reg == S_WAIT && !lb_rd_rdy && tmo_hit) begin
      err_reg <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
  assign err_q      = 1'b0;
`endif

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (any_req) state_next = S_ISSUE;
      S_ISSUE: state_next = rnw_reg ? S_WAIT : S_ACK;
      S_WAIT:  if (lb_rd_rdy || tmo_hit) state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Winner's command is captured once; master inputs are ignored until IDLE.
  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      grant_reg      <= 2'b00;
      last_grant_reg <= 1'b1;
      rnw_reg        <= 1'b0;
      addr_reg       <= '0;
      wd_reg         <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (any_req) begin
            grant_reg      <= win_idx ? 2'b10 : 2'b01;
            last_grant_reg <= win_idx;
            rnw_reg        <= win_idx ? m1_rnw  : m0_rnw;
            addr_reg       <= win_idx ? m1_addr : m0_addr;
            wd_reg         <= win_idx ? m1_wr_d : m0_wr_d;
          end
        end
        S_ACK:   grant_reg <= 2'b00;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++)
        rd_d_reg[i] <= '0;
    end else if (state_reg == S_WAIT) begin
      for (int i = 0; i < 2; i++) begin
        if (grant_reg[i]) begin
          if (lb_rd_rdy)
            rd_d_reg[i] <= lb_rd_d;
          else if (tmo_hit)
            rd_d_reg[i] <= 32'hDEADBEEF;
        end
      end
    end
  end

  always_comb begin
    lb_wr   = (state_reg == S_ISSUE) && !rnw_reg;
    lb_rd   = (state_reg == S_ISSUE) &&  rnw_reg;
    ack_vec = (state_reg == S_ACK) ? grant_reg : 2'b00;
    err_vec = ack_vec & {2{err_q}};
  end

  assign lb_addr = addr_reg;
  assign lb_wr_d = wd_reg;
  assign grant   = grant_reg;
  assign m0_ack  = ack_vec[0];
  assign m1_ack  = ack_vec[1];
  assign m0_err  = err_vec[0];
  assign m1_err  = err_vec[1];
  assign m0_rd_d = rd_d_reg[0];
  assign m1_rd_d = rd_d_reg[1];

endmodule
